// File: rtl/rr_arb_4.sv
// Four-requester round-robin arbiter with break-before-make gap and hold timeout.
// All outputs are registered; a grant is issued one cycle after the request is sampled.
module rr_arb_4 #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       en_in,
    input  logic [3:0] req_in,
    input  logic       done_in,
    output logic [3:0] gnt_out,
    output logic [1:0] gnt_idx_out,
    output logic       gnt_vld_out,
    output logic       timeout_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_gnt, w_gnt_nxt;
    logic [1:0]       r_idx, w_idx_nxt;
    logic             r_vld, w_vld_nxt;
    logic             r_timeout, w_timeout_nxt;

    logic             w_any;
    logic [1:0]       w_winner;

    // Scan from the highest offset down so the slot nearest r_ptr is written last and wins.
    always_comb begin : pick_winner
        w_any    = |req_in;
        w_winner = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req_in[r_ptr + 2'(i)]) begin
                w_winner = r_ptr + 2'(i);
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin : next_state
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = r_gnt;
        w_idx_nxt     = r_idx;
        w_vld_nxt     = r_vld;
        w_timeout_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = 4'b0000;
                w_vld_nxt = 1'b0;
                if (en_in && w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = 4'b0001 << w_winner;
                    w_idx_nxt   = w_winner;
                    w_vld_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end

            ST_GRANT: begin
                // Voluntary release (done or request drop) outranks the timeout.
                if (done_in || !req_in[r_idx] || (r_cnt == CNT_LAST)) begin
                    w_state_nxt   = ST_GAP;
                    w_gnt_nxt     = 4'b0000;
                    w_vld_nxt     = 1'b0;
                    w_ptr_nxt     = r_idx + 2'd1;
                    w_timeout_nxt = !done_in && req_in[r_idx];
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_GAP: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
                w_vld_nxt   = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
                w_vld_nxt   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 2'd0;
            r_cnt     <= '0;
            r_gnt     <= 4'b0000;
            r_idx     <= 2'd0;
            r_vld     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_idx     <= w_idx_nxt;
            r_vld     <= w_vld_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt_out     = r_gnt;
    assign gnt_idx_out = r_idx;
    assign gnt_vld_out = r_vld;
    assign timeout_out = r_timeout;

endmodule

// File: doc/rr_arb_4.md
Name: rr_arb_4

Overview:
- Four-requester round-robin arbiter for one shared resource.
- Produces a one-hot grant vector and an encoded grant index.
- Enforces break-before-make: one dead cycle between grants.
- Bounds each tenure with a hold-timeout counter.
- Sits in front of the shared datapath and sequences access to it.

Parameters:
- HOLD_MAX, 16: maximum cycles a grant may be held before forced release; legal range 2..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk_in  input  1  single clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- en_in  input  1  arbitration enable; when 0, no new grant is issued.
- req_in  input  4  request vector; bit i is requester i; level-sensitive.
- done_in  input  1  holder signals end of tenure; sampled only in GRANT.
- gnt_out  output  4  one-hot grant; all zeros when nothing is granted.
- gnt_idx_out  output  2  index of the current or last grantee.
- gnt_vld_out  output  1  1 while gnt_out is non-zero.
- timeout_out  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (rst_n_in = 0, asynchronous, takes effect immediately):
  - state = IDLE, ptr = 0, cnt = 0.
  - gnt_out = 4'b0000, gnt_idx_out = 2'b00, gnt_vld_out = 0, timeout_out = 0.
- All outputs are registered.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If en_in = 1 and req_in != 0, select the first set bit scanning ptr, ptr+1, ... modulo 4.
  - Next cycle: gnt_out = one-hot of the winner, gnt_idx_out = winner, gnt_vld_out = 1, cnt = 0, go GRANT.
  - Grant latency is 1 cycle from the first sampled request.
  - If en_in = 0 or req_in = 0, stay in IDLE with outputs idle.
- GRANT, cnt increments every cycle. Release occurs on the first of:
  - (a) done_in = 1;
  - (b) req_in[gnt_idx_out] = 0 (requester dropped);
  - (c) cnt = HOLD_MAX-1 with neither (a) nor (b). This is a forced release: timeout_out = 1 for exactly one cycle, coincident with the first GAP cycle.
  - With simultaneous causes, (a)/(b) take priority: timeout_out stays 0 if done_in or the request drop coincides with cnt = HOLD_MAX-1.
  - Maximum tenure is therefore HOLD_MAX cycles of gnt_vld_out = 1.
- On release:
  - gnt_out -> 0000 and gnt_vld_out -> 0 next cycle.
  - ptr = (gnt_idx_out + 1) mod 4; wraps 3 -> 0.
  - gnt_idx_out holds its last value.
  - Go GAP.
- GAP: one cycle, outputs idle, then IDLE unconditionally.
  - Minimum request-to-request grant spacing is therefore 2 idle cycles (GAP + IDLE evaluation).
  - A requester still asserting after its tenure has lowest priority at the next arbitration.
- en_in dropping during GRANT does not revoke the current grant; it blocks only new grants.
- Reset asserted mid-tenure drops the grant immediately, asynchronously.
- gnt_out is never more than one-hot, and is never non-zero outside GRANT.
- done_in outside GRANT is ignored.

Test Plan:
- Reset: hold rst_n_in = 0, drive req_in = 4'b1111 -> gnt_out = 0000, gnt_vld_out = 0. Assert rst_n_in mid-grant -> gnt_out = 0000 within the same cycle, before the next edge.
- Single request: en_in = 1, req_in = 0100 at cycle 0 -> gnt_out = 0100, gnt_idx_out = 2 at cycle 1. Pulse done_in at cycle 3 -> gnt_out = 0000 at cycle 4, then the next grant no earlier than cycle 6.
- Round-robin fairness: req_in = 1111 held, done_in pulsed on each tenure's 2nd cycle -> grant order 0, 1, 2, 3, 0; ptr wraps 3 -> 0.
- Timeout with HOLD_MAX = 4: req_in = 0001 held, done_in = 0 -> gnt_vld_out high exactly 4 cycles, timeout_out one pulse, then re-grant to 0 after GAP/IDLE.
- Timeout priority: done_in = 1 exactly at cnt = HOLD_MAX-1 -> release with timeout_out = 0.
- Enable gating: en_in = 0 with req_in = 0010 -> no grant. Raise en_in -> grant 0010 next cycle. Drop en_in mid-grant -> the grant persists until done_in.
